// File: rtl/debounce_pkg.sv
// Shared types and defaults for the pushbutton debouncer.
package debounce_pkg;

    // Per-button confirmation states.
    typedef enum logic [1:0] {
        SOLTO       = 2'd0,
        CONF_PRESS  = 2'd1,
        PRESSIONADO = 2'd2,
        CONF_SOLTA  = 2'd3
    } estado_t;

    // Default number of consecutive agreeing samples to accept a change.
    localparam int unsigned STABLE_TICKS_PADRAO = 8;

    // Divider output bit used as the sampling tick source (~763 Hz at 50 MHz).
    localparam int unsigned TAP_DEBOUNCE = 15;

    // Width of the per-button confirmation counter.
    localparam int unsigned CNT_W = 8;

endpackage

// File: rtl/debounce_canal.sv
// One debounced button: synchronizer, polarity fix, confirmation FSM and
// registered level / press / release outputs.
module debounce_canal
    import debounce_pkg::*;
#(
    parameter int unsigned STABLE_TICKS = STABLE_TICKS_PADRAO,
    parameter bit          ACTIVE_LOW   = 1'b1
) (
    input  logic clock_in,
    input  logic reset,
    input  logic tick,
    input  logic botao_in,
    output logic estavel,
    output logic pulso_press,
    output logic pulso_solta
);

    localparam logic [CNT_W-1:0] LIMITE        = CNT_W'(STABLE_TICKS);
    localparam logic             NIVEL_INATIVO = ACTIVE_LOW;

    logic             sync1_q;
    logic             sync2_q;
    logic             amostra;

    estado_t          estado_q;
    estado_t          estado_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic             estavel_q;
    logic             estavel_d;
    logic             press_q;
    logic             press_d;
    logic             solta_q;
    logic             solta_d;

    // Two-flop synchronizer; reset parks it at the released level.
    always_ff @(posedge clock_in) begin
        if (reset) begin
            sync1_q <= NIVEL_INATIVO;
            sync2_q <= NIVEL_INATIVO;
        end else begin
            sync1_q <= botao_in;
            sync2_q <= sync1_q;
        end
    end

    // Internal sample is 1 when the button is pressed regardless of polarity.
    assign amostra = sync2_q ^ NIVEL_INATIVO;
    assign cnt_inc = cnt_q + 1'b1;

    // Next-state logic: state and counter only move on tick cycles.
    always_comb begin
        estado_d  = estado_q;
        cnt_d     = cnt_q;
        estavel_d = estavel_q;
        press_d   = 1'b0;
        solta_d   = 1'b0;
        if (tick) begin
            case (estado_q)
                SOLTO: begin
                    if (amostra) begin
                        estado_d = CONF_PRESS;
                        cnt_d    = CNT_W'(1);
                    end
                end
                CONF_PRESS: begin
                    if (!amostra) begin
                        estado_d = SOLTO;
                        cnt_d    = '0;
                    end else if (cnt_inc == LIMITE) begin
                        estado_d  = PRESSIONADO;
                        cnt_d     = '0;
                        estavel_d = 1'b1;
                        press_d   = 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                PRESSIONADO: begin
                    if (!amostra) begin
                        estado_d = CONF_SOLTA;
                        cnt_d    = CNT_W'(1);
                    end
                end
                CONF_SOLTA: begin
                    if (amostra) begin
                        estado_d = PRESSIONADO;
                        cnt_d    = '0;
                    end else if (cnt_inc == LIMITE) begin
                        estado_d  = SOLTO;
                        cnt_d     = '0;
                        estavel_d = 1'b0;
                        solta_d   = 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                default: begin
                    estado_d = SOLTO;
                    cnt_d    = '0;
                end
            endcase
        end
    end

    // State, counter and registered outputs; reset aborts any confirmation silently.
    always_ff @(posedge clock_in) begin
        if (reset) begin
            estado_q  <= SOLTO;
            cnt_q     <= '0;
            estavel_q <= 1'b0;
            press_q   <= 1'b0;
            solta_q   <= 1'b0;
        end else begin
            estado_q  <= estado_d;
            cnt_q     <= cnt_d;
            estavel_q <= estavel_d;
            press_q   <= press_d;
            solta_q   <= solta_d;
        end
    end

    assign estavel     = estavel_q;
    assign pulso_press = press_q;
    assign pulso_solta = solta_q;

endmodule

// File: rtl/debounce_botoes.sv
// Pushbutton debouncer top: turns the ripple divider tap into a one-cycle
// sample enable and fans it out to one debounce channel per button.
module debounce_botoes
    import debounce_pkg::*;
#(
    parameter int unsigned N            = 4,
    parameter int unsigned STABLE_TICKS = STABLE_TICKS_PADRAO,
    parameter bit          ACTIVE_LOW   = 1'b1
) (
    input  logic         clock_in,
    input  logic         reset,
    input  logic         tick_src,
    input  logic [N-1:0] botoes_in,
    output logic [N-1:0] botoes_estaveis,
    output logic [N-1:0] pulso_press,
    output logic [N-1:0] pulso_solta,
    output logic         tick
);

    logic ts_sync1_q;
    logic ts_sync2_q;
    logic ts_edge_q;
    logic tick_int;

    // Synchronize the divider tap and keep its previous value for edge detection.
    always_ff @(posedge clock_in) begin
        if (reset) begin
            ts_sync1_q <= 1'b0;
            ts_sync2_q <= 1'b0;
            ts_edge_q  <= 1'b0;
        end else begin
            ts_sync1_q <= tick_src;
            ts_sync2_q <= ts_sync1_q;
            ts_edge_q  <= ts_sync2_q;
        end
    end

    // Rising edge of the synchronized tap only.
    assign tick_int = ts_sync2_q & ~ts_edge_q;
    assign tick     = tick_int;

    for (genvar i = 0; i < int'(N); i++) begin : g_canal
        debounce_canal #(
            .STABLE_TICKS (STABLE_TICKS),
            .ACTIVE_LOW   (ACTIVE_LOW)
        ) u_canal (
            .clock_in    (clock_in),
            .reset       (reset),
            .tick        (tick_int),
            .botao_in    (botoes_in[i]),
            .estavel     (botoes_estaveis[i]),
            .pulso_press (pulso_press[i]),
            .pulso_solta (pulso_solta[i])
        );
    end

endmodule

// File: tb/tb_debounce_botoes.sv
// Scoreboard bench for debounce_botoes: a run-length reference model predicts
// tick, debounced levels and press/release events; a negedge monitor checks them.
module tb_debounce_botoes;

    localparam int N    = 4;
    localparam int ST   = 4;
    localparam int MAXC = 40000;

    logic         clock_in = 1'b0;
    logic         reset    = 1'b1;
    logic         tick_src = 1'b0;
    logic [N-1:0] botoes_in = '1;
    logic [N-1:0] botoes_estaveis;
    logic [N-1:0] pulso_press;
    logic [N-1:0] pulso_solta;
    logic         tick;

    debounce_botoes #(
        .N            (N),
        .STABLE_TICKS (ST),
        .ACTIVE_LOW   (1'b1)
    ) dut (
        .clock_in        (clock_in),
        .reset           (reset),
        .tick_src        (tick_src),
        .botoes_in       (botoes_in),
        .botoes_estaveis (botoes_estaveis),
        .pulso_press     (pulso_press),
        .pulso_solta     (pulso_solta),
        .tick            (tick)
    );

    always #10 clock_in = ~clock_in;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- tick_src generator ----------------
    logic ts_run   = 1'b0;
    logic ts_level = 1'b0;
    int   ph       = 0;

    initial begin
        forever begin
            @(posedge clock_in);
            #1;
            if (ts_run) begin
                ph++;
                tick_src = ((ph % 64) >= 32);
            end else begin
                tick_src = ts_level;
            end
        end
    end

    // ---------------- reference model ----------------
    typedef struct {
        int e;
        int b;
        bit press;
    } ev_t;

    ev_t          q[$];
    logic         rst_h [MAXC];
    logic         ts_h  [MAXC];
    logic [N-1:0] pr_h  [MAXC];
    int           cyc     = 0;
    int           cur_e   = 0;
    bit           started = 0;
    logic         tick_exp = 1'b0;
    logic [N-1:0] lvl = '0;
    int           run [N];

    // Value seen d edges late through a resettable delay line (reset value 0).
    function automatic logic dly_ts(input int e, input int d);
        if (e - d < 0) return 1'b0;
        for (int k = e - d; k < e; k++) if (rst_h[k]) return 1'b0;
        return ts_h[e - d];
    endfunction

    function automatic logic [N-1:0] dly_pr(input int e, input int d);
        if (e - d < 0) return '0;
        for (int k = e - d; k < e; k++) if (rst_h[k]) return '0;
        return pr_h[e - d];
    endfunction

    always @(posedge clock_in) begin
        int e;
        logic [N-1:0] s;
        ev_t ev;
        e = cyc;
        if (e >= MAXC) begin
            $display("FAIL model_overflow actual=%0d required<%0d", e, MAXC);
            $fatal(1);
        end
        rst_h[e] = reset;
        ts_h[e]  = tick_src;
        pr_h[e]  = ~botoes_in;
        if (reset) begin
            lvl = '0;
            for (int b = 0; b < N; b++) run[b] = 0;
        end else if (dly_ts(e, 2) && !dly_ts(e, 3)) begin
            s = dly_pr(e, 2);
            for (int b = 0; b < N; b++) begin
                if (s[b] != lvl[b]) begin
                    run[b]++;
                    if (run[b] == ST) begin
                        lvl[b]   = s[b];
                        run[b]   = 0;
                        ev.e     = e;
                        ev.b     = b;
                        ev.press = s[b];
                        q.push_back(ev);
                    end
                end else begin
                    run[b] = 0;
                end
            end
        end
        tick_exp = dly_ts(e + 1, 2) & ~dly_ts(e + 1, 3);
        cur_e    = e;
        cyc      = e + 1;
        started  = 1;
    end

    // ---------------- monitor ----------------
    int press_cnt [N];
    int solta_cnt [N];
    int press_last[N];
    int matched = 0;

    always @(negedge clock_in) begin
        if (started) begin
            chk("tick", tick, tick_exp);
            chk("estaveis", botoes_estaveis, lvl);
            chk("excl", pulso_press & pulso_solta, '0);
            for (int b = 0; b < N; b++) begin
                for (int k = 0; k < 2; k++) begin
                    logic p;
                    p = (k == 0) ? pulso_press[b] : pulso_solta[b];
                    if (p) begin
                        if (k == 0) begin
                            press_cnt[b]++;
                            press_last[b] = cur_e;
                        end else begin
                            solta_cnt[b]++;
                        end
                        checks++;
                        if (q.size() > 0 && q[0].e == cur_e && q[0].b == b && q[0].press == (k == 0)) begin
                            matched++;
                            void'(q.pop_front());
                        end else begin
                            failures++;
                            $display("FAIL unexpected_pulse actual=bit%0d/%s at edge %0d required=none",
                                     b, (k == 0) ? "press" : "solta", cur_e);
                        end
                    end
                end
            end
            while (q.size() > 0 && q[0].e <= cur_e) begin
                checks++;
                failures++;
                $display("FAIL missing_pulse actual=none required=bit%0d/%s at edge %0d",
                         q[0].b, q[0].press ? "press" : "solta", q[0].e);
                void'(q.pop_front());
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            int k = 0;
            do begin
                @(negedge clock_in);
                k++;
            end while (tick !== 1'b1 && k < 200);
            if (tick !== 1'b1) begin
                checks++;
                failures++;
                $display("FAIL tick_timeout actual=no tick in %0d cycles required=tick", k);
            end
        end
    endtask

    task automatic settle();
        wait_ticks(5);
        repeat (3) @(negedge clock_in);
    endtask

    initial begin
        int pc [N];
        int sc [N];
        for (int b = 0; b < N; b++) begin
            press_cnt[b] = 0; solta_cnt[b] = 0; press_last[b] = -1; run[b] = 0;
        end

        // Reset with buttons released: everything stays 0.
        repeat (5) begin
            @(negedge clock_in);
            chk("rst_out", {botoes_estaveis, pulso_press, pulso_solta, tick}, '0);
        end
        reset = 1'b0;
        repeat (4) @(negedge clock_in);

        // One tick_src rise: tick high in the third cycle, one cycle wide.
        ts_level = 1'b1;
        @(negedge clock_in); chk("tick_rise_c1", tick, 1'b0);
        @(negedge clock_in); chk("tick_rise_c2", tick, 1'b0);
        @(negedge clock_in); chk("tick_rise_c3", tick, 1'b1);
        @(negedge clock_in); chk("tick_rise_c4", tick, 1'b0);
        repeat (6) @(negedge clock_in);
        ts_level = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock_in);
            chk("tick_fall", tick, 1'b0);
        end
        ts_run = 1'b1;

        // Clean press on bit 0.
        for (int b = 0; b < N; b++) pc[b] = press_cnt[b];
        botoes_in = 4'b1110;
        settle();
        chk("press0_level", botoes_estaveis, 4'b0001);
        chk("press0_count", press_cnt[0] - pc[0], 1);

        // Bounce on bit 1, then held.
        pc[1] = press_cnt[1];
        for (int i = 0; i < 15; i++) begin
            botoes_in[1] = ~botoes_in[1];
            repeat (40) @(negedge clock_in);
        end
        chk("bounce_nopulse", press_cnt[1] - pc[1], 0);
        botoes_in = 4'b1100;
        settle();
        chk("bounce_level", botoes_estaveis, 4'b0011);
        chk("bounce_count", press_cnt[1] - pc[1], 1);

        // Release everything.
        for (int b = 0; b < N; b++) begin pc[b] = press_cnt[b]; sc[b] = solta_cnt[b]; end
        botoes_in = 4'b1111;
        settle();
        chk("release_level", botoes_estaveis, 4'b0000);
        chk("release0_count", solta_cnt[0] - sc[0], 1);
        chk("release_nopress", press_cnt[0] - pc[0], 0);

        // Simultaneous press of bits 2 and 3.
        for (int b = 0; b < N; b++) pc[b] = press_cnt[b];
        botoes_in = 4'b0011;
        settle();
        chk("simul_level", botoes_estaveis, 4'b1100);
        chk("simul_count2", press_cnt[2] - pc[2], 1);
        chk("simul_count3", press_cnt[3] - pc[3], 1);
        chk("simul_same_cycle", press_last[2], press_last[3]);
        botoes_in = 4'b1111;
        settle();

        // Reset one cycle after the second pressed tick.
        wait_ticks(1);
        botoes_in = 4'b1110;
        pc[0] = press_cnt[0];
        wait_ticks(2);
        @(negedge clock_in);
        reset = 1'b1;
        @(negedge clock_in);
        chk("midrst_level", botoes_estaveis, 4'b0000);
        reset = 1'b0;
        wait_ticks(3);
        repeat (3) @(negedge clock_in);
        chk("midrst_nopulse", press_cnt[0] - pc[0], 0);
        wait_ticks(1);
        repeat (3) @(negedge clock_in);
        chk("midrst_accept", press_cnt[0] - pc[0], 1);
        chk("midrst_level2", botoes_estaveis, 4'b0001);

        // Randomized traffic: glitches, long holds, occasional resets.
        for (int it = 0; it < 60; it++) begin
            int r;
            r = $urandom_range(0, 15);
            if (r == 0) begin
                reset = 1'b1;
                repeat ($urandom_range(1, 3)) @(negedge clock_in);
                reset = 1'b0;
            end else begin
                botoes_in = N'($urandom);
                repeat ((r < 5) ? $urandom_range(1, 20) : $urandom_range(20, 400)) @(negedge clock_in);
            end
        end
        botoes_in = N'($urandom);
        repeat (600) @(negedge clock_in);
        botoes_in = 4'b1111;
        repeat (600) @(negedge clock_in);

        chk("queue_drained", q.size(), 0);
        chk("events_seen", (matched > 10) ? 1 : 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        repeat (38000) @(posedge clock_in);
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule

// File: doc/debounce_botoes.md
# debounce_botoes

Debounces and edge-detects the board pushbuttons, sampling them at a slow tick taken from one output bit of the ripple frequency divider. The block sits directly downstream of the divider. It converts the asynchronous divider tap into a one-cycle enable in the 50 MHz domain, then runs one confirmation state machine per button. Its outputs are clean levels and single-cycle press/release pulses for the control logic.

## Interface
- N, 4: number of buttons (1..16).
- STABLE_TICKS, 8: consecutive agreeing samples needed to accept a change (2..255).
- ACTIVE_LOW, 1: 1 = raw button reads 0 when pressed (board default); 0 = active-high.
- clock_in  in  1  50 MHz system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- tick_src  in  1  divider tap (clock_out[15], ~763 Hz); ripple-derived, treated as asynchronous.
- botoes_in  in  N  raw pushbutton levels, asynchronous.
- botoes_estaveis  out  N  debounced level, 1 = pressed.
- pulso_press  out  N  one-cycle pulse when a press is accepted.
- pulso_solta  out  N  one-cycle pulse when a release is accepted.
- tick  out  1  internal sample enable, one cycle wide (observability).

## Operation
- Tick generation:
  - tick_src passes through 2 sync flops, then an edge register.
  - tick = sync2 & ~edge.
  - Rising edges only; falling edges ignored.
- Button path:
  - Each bit has its own 2-flop synchronizer.
  - If ACTIVE_LOW, the bit is inverted, so internal sample 1 = pressed.
- Per-button FSM, 2-bit state, counter cnt of 8 bits:
  - SOLTO: on tick with sample=1 -> CONF_PRESS, cnt=1.
  - CONF_PRESS:
    - On tick with sample=1: cnt+1. When cnt+1 == STABLE_TICKS -> PRESSIONADO; set estavel=1; pulse press.
    - On tick with sample=0: -> SOLTO, cnt=0.
  - PRESSIONADO: on tick with sample=0 -> CONF_SOLTA, cnt=1.
  - CONF_SOLTA: mirror of CONF_PRESS. Acceptance -> SOLTO, estavel=0, pulse release. A tick with sample=1 returns to PRESSIONADO.
  - State and cnt change only on tick cycles. Between ticks the sample is ignored, so glitches shorter than one tick period are invisible.
- Bits are fully independent. Simultaneous acceptances on several bits pulse in the same cycle.
- pulso_press and pulso_solta are never both high on one bit.

## Timing
- Reset values:
  - All outputs 0; every FSM in SOLTO; cnt 0.
  - Tick sync and edge flops 0.
  - Button sync flops hold the inactive level (1 if ACTIVE_LOW).
- tick_src rise -> tick high 3 cycles later (2 sync + edge), for exactly 1 cycle.
- tick_src already high at reset release -> one tick 2 cycles after release. This is harmless, since no FSM can accept on one sample.
- Acceptance is registered. botoes_estaveis and the pulse update on the clock edge after the accepting tick cycle.
- Press latency, raw input to pulse: 2 sync cycles + (STABLE_TICKS-1) to STABLE_TICKS tick periods + 1 cycle. Defaults give ~9.2-10.5 ms.
- Reset mid-confirmation aborts the confirmation:
  - The FSM returns to SOLTO with no pulse.
  - A button still held after reset needs a full STABLE_TICKS new samples.
- A reset asserted in PRESSIONADO clears botoes_estaveis without a pulso_solta.

## Structure
- Package debounce_pkg:
  - estado_t (SOLTO, CONF_PRESS, PRESSIONADO, CONF_SOLTA).
  - Defaults STABLE_TICKS_PADRAO=8.
  - Tap index TAP_DEBOUNCE=15.
- Sub-module debounce_canal, instantiated N times with generate. It holds the button synchronizer, polarity inversion, FSM, counter, and the 3 outputs of one button.
- Top level holds only the tick synchronizer and edge detector.

## Test plan
Bench settings: N=4, STABLE_TICKS=4, ACTIVE_LOW=1, tick_src modelled as period 64 clocks.
- Reset and tick check:
  - Stimulus: reset 5 cycles with botoes_in=4'b1111; then one tick_src rise.
  - Required: all outputs 0 during reset. The tick_src rise gives tick 3 cycles later, 1 cycle wide. No tick on the falling edge.
- Clean press:
  - Stimulus: botoes_in=4'b1110, held.
  - Required: pulso_press=4'b0001 for one cycle, 1 cycle after the 4th tick. Then botoes_estaveis=4'b0001; other bits 0.
- Bounce rejection:
  - Stimulus: bit1 toggles every 40 clocks for 600 clocks, then held low.
  - Required: no pulse during the bounce. Exactly one pulso_press[1] after 4 stable ticks.
- Release:
  - Stimulus: from bit0 pressed, botoes_in=4'b1111.
  - Required: exactly one pulso_solta[0] after 4 ticks; botoes_estaveis[0]=0; pulso_press stays 0.
- Simultaneous press:
  - Stimulus: bits 2 and 3 pressed in the same cycle.
  - Required: pulso_press=4'b1100 in a single cycle.
- Reset mid-confirmation:
  - Stimulus: reset 1 cycle after the 2nd pressed tick, button held throughout.
  - Required: no pulse. The press is accepted only after 4 further ticks.
